mips_register_file: RTL

MIPS_REGISTER_FILE -- requirements
Module: mips_register_file

---
 rtl/mips_register_file.sv | 82 ++++++++
 1 files changed

// File: rtl/mips_register_file.sv
// 32-entry MIPS general-purpose register file: two combinational read ports,
// one write-back port with same-cycle forwarding, hardwired r0, commit counter.
module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [15:0]       wr_count
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [NREGS];
    logic [15:0]       wr_count_q;
    logic [15:0]       wr_count_d;
    logic              commit;

    // r0 is never a legal destination, so such writes neither land nor count.
    assign commit = we && (waddr != '0);

    // NOTE: every storage entry is cleared by the async reset, because software
    // expects all registers to read zero out of reset; this costs a flop array
    // rather than a RAM macro, which is the norm for a register file this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (commit) begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            regs_q[waddr] <= wdata;
        end
    end

    always_comb begin
        wr_count_d = wr_count_q;
        if (commit) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else begin
            wr_count_q <= wr_count_d;
        end
    end

    // Forward the in-flight write-back so an instruction reading its own
    // producer's destination sees the new value; suppressed while in reset.
    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] raddr);
        logic [DATA_W-1:0] value;
        // NOTE: the result gets a default first so no path can infer a latch.
        value = '0;
        if (!rst_n || raddr == '0) begin
            value = '0;
        end else if (commit && raddr == waddr) begin
            value = wdata;
        end else begin
            value = regs_q[raddr];
        end
        return value;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

    assign wr_count = wr_count_q;

endmodule
